// File: rtl/lsu_ost_buf.sv
// lsu_ost_buf: buffered load/store unit between the core LSU source and the
// memory-side generator.
//   - Requests are queued in a REQ_DEPTH FIFO and issued in order, with at
//     most MAX_OST accesses in flight.
//   - Each issued access records {offset, size} in a tag FIFO so that read
//     data can be realigned and zero-extended as responses return.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   src_req_* (vld/rdy/addr/wr/size/wdata)  core request in
//   src_rsp_* (vld/rdy/rdata/err)           core response out
//   gen_req_* (vld/rdy/addr/wr/wstrb/wdata) memory request out
//   gen_rsp_* (vld/rdy/rdata/err)           memory response in
//   ost_cnt                            accesses issued without a response
//   idle                               nothing queued or in flight
// Optional feature macro: LSU_MISALIGN_CHK_EN. When defined, a misaligned or
// illegal-size head is never issued; it waits for older accesses to drain
// and is then answered locally with an error response.
module lsu_ost_buf #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned REQ_DEPTH = 2,
  parameter int unsigned MAX_OST   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         src_req_vld,
  output logic                         src_req_rdy,
  input  logic [AW-1:0]                src_req_addr,
  input  logic                         src_req_wr,
  input  logic [1:0]                   src_req_size,
  input  logic [DW-1:0]                src_req_wdata,
  output logic                         src_rsp_vld,
  input  logic                         src_rsp_rdy,
  output logic [DW-1:0]                src_rsp_rdata,
  output logic                         src_rsp_err,
  output logic                         gen_req_vld,
  input  logic                         gen_req_rdy,
  output logic [AW-1:0]                gen_req_addr,
  output logic                         gen_req_wr,
  output logic [DW/8-1:0]              gen_req_wstrb,
  output logic [DW-1:0]                gen_req_wdata,
  input  logic                         gen_rsp_vld,
  output logic                         gen_rsp_rdy,
  input  logic [DW-1:0]                gen_rsp_rdata,
  input  logic                         gen_rsp_err,
  output logic [$clog2(MAX_OST+1)-1:0] ost_cnt,
  output logic                         idle
);

  localparam int unsigned NB  = DW / 8;
  localparam int unsigned SZW = $clog2(NB);
  localparam int unsigned OW  = $clog2(MAX_OST + 1);
  localparam int unsigned RCW = $clog2(REQ_DEPTH + 1);
  localparam int unsigned RPW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned TPW = (MAX_OST > 1) ? $clog2(MAX_OST) : 1;

  localparam logic [1:0] RUN   = 2'd0;
`ifdef LSU_MISALIGN_CHK_EN
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] ERR   = 2'd2;
`endif

  // request FIFO storage and pointers
  logic [AW-1:0]  r_addr  [REQ_DEPTH];
  logic           r_wr    [REQ_DEPTH];
  logic [1:0]     r_size  [REQ_DEPTH];
  logic [DW-1:0]  r_wdata [REQ_DEPTH];
  logic [RPW-1:0] r_wp, r_rp;
  logic [RCW-1:0] r_cnt;

  // tag FIFO: occupancy always equals r_ost
  logic [SZW-1:0] r_tag_off  [MAX_OST];
  logic [1:0]     r_tag_size [MAX_OST];
  logic [TPW-1:0] r_twp, r_trp;
  logic [OW-1:0]  r_ost;

  logic [1:0]     r_state, w_state_nxt;

  logic           w_empty, w_full, w_push, w_pop, w_issue, w_rsp_fire;
  logic           w_err, w_err_pop, w_head_bad, w_size_ill, w_can_issue;
  logic           w_gen_rsp_ok;
  logic [AW-1:0]  w_haddr;
  logic [1:0]     w_hsize;
  logic [SZW-1:0] w_off, w_toff;
  logic [1:0]     w_tsize;
  logic [NB-1:0]  w_strb;
  logic [DW-1:0]  w_mask;
  int             w_nbytes;

  function automatic logic [RPW-1:0] rp_inc(input logic [RPW-1:0] p);
    return (p == RPW'(REQ_DEPTH - 1)) ? '0 : RPW'(p + RPW'(1));
  endfunction

  function automatic logic [TPW-1:0] tp_inc(input logic [TPW-1:0] p);
    return (p == TPW'(MAX_OST - 1)) ? '0 : TPW'(p + TPW'(1));
  endfunction

  // head decode, strobe and alignment checks
  always_comb begin
    w_empty    = (r_cnt == '0);
    w_full     = (r_cnt == RCW'(REQ_DEPTH));
    w_haddr    = r_addr[r_rp];
    w_hsize    = r_size[r_rp];
    w_off      = w_haddr[SZW-1:0];
    w_size_ill = int'(w_hsize) > int'(SZW);
    w_nbytes   = 1 << w_hsize;
    for (int i = 0; i < int'(NB); i++) begin
      w_strb[i] = w_size_ill ||
                  ((i >= int'(w_off)) && (i < int'(w_off) + w_nbytes));
    end
`ifdef LSU_MISALIGN_CHK_EN
    w_head_bad = !w_empty &&
                 (w_size_ill || ((w_haddr & AW'(w_nbytes - 1)) != '0));
    w_err      = (r_state == ERR);
`else
    w_head_bad = 1'b0;
    w_err      = 1'b0;
`endif
  end

  // next-state logic; without the check the FSM never leaves RUN
  always_comb begin
    w_state_nxt = r_state;
`ifdef LSU_MISALIGN_CHK_EN
    case (r_state)
      RUN:     if (w_head_bad) w_state_nxt = (r_ost == '0) ? ERR : DRAIN;
      DRAIN:   if (r_ost == '0) w_state_nxt = ERR;
      ERR:     if (src_rsp_rdy) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
`else
    w_state_nxt = RUN;
`endif
  end

  // handshakes and outputs
  always_comb begin
    w_can_issue  = !w_empty && (r_ost < OW'(MAX_OST)) && (r_state == RUN) && !w_head_bad;
    w_gen_rsp_ok = (r_ost != '0) && !w_err;
    w_toff       = r_tag_off[r_trp];
    w_tsize      = r_tag_size[r_trp];
    for (int j = 0; j < int'(DW); j++) begin
      w_mask[j] = (j < (8 << w_tsize));
    end

    src_req_rdy   = !w_full;
    gen_req_vld   = w_can_issue;
    gen_req_addr  = w_can_issue ? w_haddr : '0;
    gen_req_wr    = w_can_issue && r_wr[r_rp];
    gen_req_wstrb = w_can_issue ? w_strb : '0;
    gen_req_wdata = w_can_issue ? (r_wdata[r_rp] << {w_off, 3'b000}) : '0;

    gen_rsp_rdy   = src_rsp_rdy && w_gen_rsp_ok;
    src_rsp_vld   = w_err || (gen_rsp_vld && w_gen_rsp_ok);
    src_rsp_err   = w_err || (gen_rsp_vld && w_gen_rsp_ok && gen_rsp_err);
    src_rsp_rdata = (gen_rsp_vld && w_gen_rsp_ok) ?
                    ((gen_rsp_rdata >> {w_toff, 3'b000}) & w_mask) : '0;

    w_push     = src_req_vld && !w_full;
    w_issue    = w_can_issue && gen_req_rdy;
    w_err_pop  = w_err && src_rsp_rdy;
    w_pop      = w_issue || w_err_pop;
    w_rsp_fire = gen_rsp_vld && gen_rsp_rdy;

    ost_cnt = r_ost;
    idle    = w_empty && (r_ost == '0) && (r_state == RUN);
  end

  // state, FIFOs and in-flight counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_twp   <= '0;
      r_trp   <= '0;
      r_ost   <= '0;
      for (int k = 0; k < int'(REQ_DEPTH); k++) begin
        r_addr[k]  <= '0;
        r_wr[k]    <= 1'b0;
        r_size[k]  <= '0;
        r_wdata[k] <= '0;
      end
      for (int k = 0; k < int'(MAX_OST); k++) begin
        r_tag_off[k]  <= '0;
        r_tag_size[k] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_addr[r_wp]  <= src_req_addr;
        r_wr[r_wp]    <= src_req_wr;
        r_size[r_wp]  <= src_req_size;
        r_wdata[r_wp] <= src_req_wdata;
        r_wp          <= rp_inc(r_wp);
      end
      if (w_pop) r_rp <= rp_inc(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + RCW'(1);
        2'b01:   r_cnt <= r_cnt - RCW'(1);
        default: ;
      endcase
      if (w_issue) begin
        r_tag_off[r_twp]  <= w_off;
        r_tag_size[r_twp] <= w_hsize;
        r_twp             <= tp_inc(r_twp);
      end
      if (w_rsp_fire) r_trp <= tp_inc(r_trp);
      case ({w_issue, w_rsp_fire})
        2'b10:   r_ost <= r_ost + OW'(1);
        2'b01:   r_ost <= r_ost - OW'(1);
        default: ;
      endcase
    end
  end

endmodule
